// File: rtl/csa_resolve_seq.sv
// Chunked carry-propagate adder resolving a carry-save pair to one binary word.
// Optional carry-out port enabled by defining CSR_CARRY_OUT_EN.
module csa_resolve_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_s,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum
`ifdef CSR_CARRY_OUT_EN
  ,
  output logic             o_cout
`endif
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] c_q, c_d, s_q, s_d;
  logic [CHUNK:0]   add_res;
`ifdef CSR_CARRY_OUT_EN
  logic             cout_q, cout_d;
`endif

  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  endfunction

  // Operands shift right one chunk per cycle, so the low chunk is always the
  // one being added; results enter at the top and settle into place after NCH.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_d     = c_q;
    s_d     = s_q;
`ifdef CSR_CARRY_OUT_EN
    cout_d  = cout_q;
`endif
    add_res = chunk_add(c_q[CHUNK-1:0], s_q[CHUNK-1:0], carry_q);
    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          c_d     = i_c;
          s_d     = i_s;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        c_d     = c_q >> CHUNK;
        s_d     = s_q >> CHUNK;
        sum_d   = (sum_q >> CHUNK) | (WIDTH'(add_res[CHUNK-1:0]) << (WIDTH - CHUNK));
        carry_d = add_res[CHUNK];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
`ifdef CSR_CARRY_OUT_EN
          cout_d  = add_res[CHUNK];
`endif
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      sum_q   <= '0;
`ifdef CSR_CARRY_OUT_EN
      cout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
`ifdef CSR_CARRY_OUT_EN
      cout_q  <= cout_d;
`endif
    end
  end

  // Operand registers are pure datapath and need no reset.
  always_ff @(posedge i_clk) begin
    c_q <= c_d;
    s_q <= s_d;
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_sum   = sum_q;
`ifdef CSR_CARRY_OUT_EN
  assign o_cout  = cout_q;
`endif

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Bench for csa_resolve_seq: directed vector table, handshake corner cases,
// and randomized traffic on three instances (CHUNK = 8, 4, 32).
module tb_csa_resolve_seq;

  logic        clk;
  logic        rst_n;
  logic        vld[3];
  logic        rdy_dn[3];
  logic [31:0] cin[3];
  logic [31:0] sin[3];
  logic        rdy_up[3];
  logic        ov[3];
  logic [31:0] sum[3];
`ifdef CSR_CARRY_OUT_EN
  logic        cout[3];
`endif

  int n_vec;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  csa_resolve_seq #(.WIDTH(32), .CHUNK(8)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[0]), .o_ready(rdy_up[0]),
    .i_c(cin[0]), .i_s(sin[0]), .o_valid(ov[0]), .i_ready(rdy_dn[0]), .o_sum(sum[0])
`ifdef CSR_CARRY_OUT_EN
    , .o_cout(cout[0])
`endif
  );

  csa_resolve_seq #(.WIDTH(32), .CHUNK(4)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[1]), .o_ready(rdy_up[1]),
    .i_c(cin[1]), .i_s(sin[1]), .o_valid(ov[1]), .i_ready(rdy_dn[1]), .o_sum(sum[1])
`ifdef CSR_CARRY_OUT_EN
    , .o_cout(cout[1])
`endif
  );

  csa_resolve_seq #(.WIDTH(32), .CHUNK(32)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[2]), .o_ready(rdy_up[2]),
    .i_c(cin[2]), .i_s(sin[2]), .o_valid(ov[2]), .i_ready(rdy_dn[2]), .o_sum(sum[2])
`ifdef CSR_CARRY_OUT_EN
    , .o_cout(cout[2])
`endif
  );

  typedef struct {
    logic [31:0] c;
    logic [31:0] s;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present a pair and hold it until accepted; returns #1 after the accept edge.
  task automatic accept(input int k, input logic [31:0] c, input logic [31:0] s);
    int guard;
    cin[k] = c;
    sin[k] = s;
    vld[k] = 1'b1;
    guard  = 0;
    while (!rdy_up[k] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("accept_wait", 32'(guard < 50), 32'd1);
    @(posedge clk); #1;
    vld[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, output int lat);
    lat = 0;
    while (!ov[k] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_random(input int k, input int n);
    logic [31:0] q[$];
    logic [31:0] exp;
    logic        acc;
    logic        outh;
    int          sent;
    int          got;
    int          cyc;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < n && cyc < n * 40) begin
      if (!vld[k] && sent < n && $urandom_range(3) != 0) begin
        cin[k] = $urandom;
        sin[k] = $urandom;
        vld[k] = 1'b1;
      end
      rdy_dn[k] = ($urandom_range(3) != 0);
      acc  = vld[k] && rdy_up[k];
      outh = ov[k] && rdy_dn[k];
      if (outh) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rnd_dup[%0d]: got extra result %h, expected none", k, sum[k]);
        end else begin
          exp = q.pop_front();
          chk($sformatf("rnd_sum[%0d]", k), sum[k], exp);
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        q.push_back(cin[k] + sin[k]);
        vld[k] = 1'b0;
        sent++;
      end
    end
    chk($sformatf("rnd_count[%0d]", k), got, n);
    chk($sformatf("rnd_left[%0d]", k), q.size(), 0);
    vld[k]    = 1'b0;
    rdy_dn[k] = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int seen;
    n_vec = 0;
    n_err = 0;
    tbl[0] = '{32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    tbl[2] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    tbl[3] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};
    tbl[4] = '{32'h00FF_00FF, 32'h0001_0001, 32'h0100_0100, 1'b0};
    tbl[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
    tbl[6] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[7] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0};
    tbl[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};

    for (int k = 0; k < 3; k++) begin
      vld[k]    = 1'b0;
      rdy_dn[k] = 1'b1;
      cin[k]    = '0;
      sin[k]    = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rdy_up[0]), 32'd1);
    chk("rst_valid", 32'(ov[0]), 32'd0);
    chk("rst_sum", sum[0], 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      accept(0, tbl[i].c, tbl[i].s);
      chk($sformatf("busy[%0d]", i), 32'(rdy_up[0]), 32'd0);
      wait_valid(0, lat);
      chk($sformatf("lat[%0d]", i), lat, 4);
      chk($sformatf("sum[%0d]", i), sum[0], tbl[i].sum);
`ifdef CSR_CARRY_OUT_EN
      chk($sformatf("cout[%0d]", i), 32'(cout[0]), 32'(tbl[i].cout));
`endif
    end
    @(posedge clk); #1;

    // Backpressure: result held in DONE while a new pair waits upstream.
    rdy_dn[0] = 1'b0;
    accept(0, 32'h0F0F_0F0F, 32'h0101_0101);
    wait_valid(0, lat);
    cin[0] = 32'hDEAD_BEEF;
    sin[0] = 32'h0000_0001;
    vld[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(ov[0]), 32'd1);
      chk("bp_sum", sum[0], 32'h1010_1010);
      chk("bp_ready", 32'(rdy_up[0]), 32'd0);
    end
    rdy_dn[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_valid", 32'(ov[0]), 32'd0);
    chk("bp_rel_ready", 32'(rdy_up[0]), 32'd1);
    @(posedge clk); #1;
    chk("bp_next_busy", 32'(rdy_up[0]), 32'd0);
    vld[0] = 1'b0;
    rdy_dn[0] = 1'b0;
    wait_valid(0, lat);
    chk("bp_next_sum", sum[0], 32'hDEAD_BEF0);

    // Asynchronous reset between edges while holding a result.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_sum", sum[0], 32'd0);
    chk("async_valid", 32'(ov[0]), 32'd0);
    chk("async_ready", 32'(rdy_up[0]), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_dn[0] = 1'b1;

    // Reset after chunk 1: the partial result must never appear.
    accept(0, 32'hFFFF_FFFF, 32'h0000_0001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (ov[0]) seen++;
      @(posedge clk); #1;
    end
    chk("midadd_no_valid", seen, 0);
    accept(0, 32'h1234_5678, 32'h1111_1111);
    wait_valid(0, lat);
    chk("midadd_lat", lat, 4);
    chk("midadd_sum", sum[0], 32'h2345_6789);
    @(posedge clk); #1;

    run_random(0, 1000);
    run_random(1, 1000);
    run_random(2, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
